pov_addr_mapper: RTL and testbench

POV_ADDR_MAPPER -- requirements
Module: pov_addr_mapper

---
 rtl/pov_addr_mapper.sv | 191 +++++++++++++++++++
 tb/tb_pov_addr_mapper.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pov_addr_mapper.sv
// Purpose: POV display address generator; tracks rotor angle from the break-beam and maps (frame, LED, angle) to a texture ROM address.
// Latency: rom_addr/addr_valid are registered 2 cycles after px_num; theta, frame_cur and stalled come straight from state registers.
// Backpressure: none; free-running, and the strip driver samples rom_addr whenever addr_valid is high. Optional auto frame advance: POV_AUTO_ADVANCE_EN.
module pov_addr_mapper #(
    parameter int   LED_COUNT   = 52,
    parameter int   TEX_WIDTH   = 256,
    parameter int   NUM_FRAMES  = 24,
    parameter int   THETA_BITS  = 6,
    parameter int   PERIOD_BITS = 28,
    localparam int  FRAME_SIZE  = TEX_WIDTH * LED_COUNT,
    localparam int  ADDR_W      = $clog2(FRAME_SIZE * NUM_FRAMES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rev_in,
    input  logic [5:0]            px_num,
    input  logic [7:0]            frame_req,
    input  logic                  auto_en,
    input  logic [7:0]            auto_div,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  addr_valid,
    output logic [THETA_BITS-1:0] theta,
    output logic [7:0]            frame_cur,
    output logic                  stalled
);

    localparam logic [PERIOD_BITS-1:0] CNT_MAX   = {PERIOD_BITS{1'b1}};
    localparam logic [PERIOD_BITS-1:0] CNT_ONE   = PERIOD_BITS'(1);
    localparam logic [THETA_BITS-1:0]  THETA_MAX = {THETA_BITS{1'b1}};

    logic                   rev_q;
    logic                   rev_edge;
    logic [PERIOD_BITS-1:0] period_cnt_q, period_cnt_d;
    logic [PERIOD_BITS-1:0] period_lat_q, period_lat_d;
    logic [PERIOD_BITS-1:0] sub_cnt_q, sub_cnt_d;
    logic [PERIOD_BITS-1:0] step;
    logic [THETA_BITS-1:0]  theta_q, theta_d;
    logic                   stalled_w;
    logic [7:0]             frame_cur_q, frame_cur_d;
    logic [7:0]             frame_req_cl;
    logic [5:0]             px_cl;
    logic [ADDR_W-1:0]      base_d, col_d;
    logic [ADDR_W-1:0]      s1_base_q, s1_col_q;
    logic                   s1_vld_d, s1_vld_q;
    logic [ADDR_W-1:0]      rom_addr_q;
    logic                   addr_valid_q;

    assign rev_edge  = rev_in & ~rev_q;
    // A saturated period counter means the rotor has stopped (or never spun up).
    assign stalled_w = (period_cnt_q == CNT_MAX);

    // Revolution period measurement. The counter stays at 0 until the first
    // edge after reset, so that edge latches 0 (a partial revolution is not a
    // period) and addressing only becomes valid after a second edge.
    always_comb begin
        period_cnt_d = period_cnt_q;
        period_lat_d = period_lat_q;
        if (rev_edge) begin
            period_cnt_d = CNT_ONE;
            // Coming out of a stall the count is meaningless; keep the old period.
            if (!stalled_w) begin
                period_lat_d = period_cnt_q;
            end
        end else if ((period_cnt_q != '0) && !stalled_w) begin
            period_cnt_d = period_cnt_q + CNT_ONE;
        end
    end

    // Angle step: cycles per theta increment, never below 1.
    always_comb begin
        step = period_lat_q >> THETA_BITS;
        if (step == '0) begin
            step = CNT_ONE;
        end
    end

    // Angle tracker: theta advances once per step cycles and parks at its top value.
    always_comb begin
        sub_cnt_d = sub_cnt_q;
        theta_d   = theta_q;
        if (rev_edge) begin
            sub_cnt_d = '0;
            theta_d   = '0;
        end else if (sub_cnt_q >= (step - CNT_ONE)) begin
            sub_cnt_d = '0;
            if (theta_q != THETA_MAX) begin
                theta_d = theta_q + THETA_BITS'(1);
            end
        end else begin
            sub_cnt_d = sub_cnt_q + CNT_ONE;
        end
    end

    assign frame_req_cl = (int'(frame_req) >= NUM_FRAMES) ? 8'(NUM_FRAMES - 1) : frame_req;

`ifdef POV_AUTO_ADVANCE_EN
    logic       auto_en_q;
    logic       auto_toggle;
    logic [7:0] rev_cnt_q, rev_cnt_d;

    assign auto_toggle = auto_en ^ auto_en_q;

    // Frame select, changed only on a revolution edge so a frame never tears.
    // Toggling auto mode restarts the revolution count and suppresses an
    // advance on a coincident edge.
    always_comb begin
        rev_cnt_d   = rev_cnt_q;
        frame_cur_d = frame_cur_q;
        if (auto_toggle) begin
            rev_cnt_d = '0;
        end else if (rev_edge && auto_en) begin
            if (rev_cnt_q >= auto_div) begin
                rev_cnt_d   = '0;
                frame_cur_d = (int'(frame_cur_q) >= NUM_FRAMES - 1) ? 8'd0 : frame_cur_q + 8'd1;
            end else begin
                rev_cnt_d = rev_cnt_q + 8'd1;
            end
        end
        if (rev_edge && !auto_en) begin
            frame_cur_d = frame_req_cl;
        end
    end

    // Auto-advance state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_en_q <= 1'b0;
            rev_cnt_q <= '0;
        end else begin
            auto_en_q <= auto_en;
            rev_cnt_q <= rev_cnt_d;
        end
    end
`else
    // Auto-advance controls are present on the port list but have no effect in this build.
    logic unused_auto;
    assign unused_auto = ^{auto_en, auto_div};

    // Frame select, changed only on a revolution edge so a frame never tears.
    always_comb begin
        frame_cur_d = frame_cur_q;
        if (rev_edge) begin
            frame_cur_d = frame_req_cl;
        end
    end
`endif

    // Address stage-1 operands: frame/LED base and texture column for the current angle.
    always_comb begin
        px_cl    = (int'(px_num) >= LED_COUNT) ? 6'(LED_COUNT - 1) : px_num;
        base_d   = ADDR_W'(frame_cur_q) * ADDR_W'(FRAME_SIZE) + ADDR_W'(px_cl) * ADDR_W'(TEX_WIDTH);
        col_d    = ADDR_W'((int'(theta) * TEX_WIDTH) >> THETA_BITS);
        s1_vld_d = (period_lat_q != '0) && !stalled_w;
    end

    // All state registers plus the two-stage address pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rev_q        <= 1'b0;
            period_cnt_q <= '0;
            period_lat_q <= '0;
            sub_cnt_q    <= '0;
            theta_q      <= '0;
            frame_cur_q  <= '0;
            s1_base_q    <= '0;
            s1_col_q     <= '0;
            s1_vld_q     <= 1'b0;
            rom_addr_q   <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            rev_q        <= rev_in;
            period_cnt_q <= period_cnt_d;
            period_lat_q <= period_lat_d;
            sub_cnt_q    <= sub_cnt_d;
            theta_q      <= theta_d;
            frame_cur_q  <= frame_cur_d;
            s1_base_q    <= base_d;
            s1_col_q     <= col_d;
            s1_vld_q     <= s1_vld_d;
            rom_addr_q   <= s1_base_q + s1_col_q;
            addr_valid_q <= s1_vld_q;
        end
    end

    assign theta      = stalled_w ? '0 : theta_q;
    assign stalled    = stalled_w;
    assign frame_cur  = frame_cur_q;
    assign rom_addr   = rom_addr_q;
    assign addr_valid = addr_valid_q;

endmodule

// File: tb/tb_pov_addr_mapper.sv
// Bench for pov_addr_mapper: default-parameter instance against a revolution-level
// reference model, plus a PERIOD_BITS=10 instance for stall behaviour.
module tb_pov_addr_mapper;

    localparam int LED_COUNT  = 52;
    localparam int TEX_WIDTH  = 256;
    localparam int NUM_FRAMES = 24;
    localparam int THETA_BITS = 6;
    localparam int FRAME_SIZE = TEX_WIDTH * LED_COUNT;
    localparam int ADDR_W     = $clog2(FRAME_SIZE * NUM_FRAMES);
    localparam int THETA_TOP  = (1 << THETA_BITS) - 1;
    localparam longint CNT_MAX = (longint'(1) << 28) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  rev_in;
    logic                  rev_s;
    logic [5:0]            px_num;
    logic [7:0]            frame_req;
    logic                  auto_en;
    logic [7:0]            auto_div;
    logic [ADDR_W-1:0]     rom_addr, rom_addr_s;
    logic                  addr_valid, addr_valid_s;
    logic [THETA_BITS-1:0] theta, theta_s;
    logic [7:0]            frame_cur, frame_cur_s;
    logic                  stalled, stalled_s;

    pov_addr_mapper dut (
        .clk(clk), .reset(reset), .rev_in(rev_in), .px_num(px_num),
        .frame_req(frame_req), .auto_en(auto_en), .auto_div(auto_div),
        .rom_addr(rom_addr), .addr_valid(addr_valid), .theta(theta),
        .frame_cur(frame_cur), .stalled(stalled)
    );

    pov_addr_mapper #(.PERIOD_BITS(10)) dut_s (
        .clk(clk), .reset(reset), .rev_in(rev_s), .px_num(px_num),
        .frame_req(frame_req), .auto_en(auto_en), .auto_div(auto_div),
        .rom_addr(rom_addr_s), .addr_valid(addr_valid_s), .theta(theta_s),
        .frame_cur(frame_cur_s), .stalled(stalled_s)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          vld;
        int unsigned addr;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: cycles since last edge, latched period, frame.
    int m_n;
    int m_lat;
    bit m_armed;
    int m_frame;
    bit m_rev_prev;
    int m_revs;
    bit m_auto_prev;

    function automatic int clamp_frame(int f);
        return (f >= NUM_FRAMES) ? NUM_FRAMES - 1 : f;
    endfunction

    function automatic int clamp_px(int p);
        return (p >= LED_COUNT) ? LED_COUNT - 1 : p;
    endfunction

    function automatic int m_step();
        int s;
        s = m_lat >> THETA_BITS;
        return (s == 0) ? 1 : s;
    endfunction

    function automatic bit m_stalled();
        return m_armed && ((longint'(m_n) + 1) >= CNT_MAX);
    endfunction

    function automatic int m_theta();
        int t;
        if (m_stalled()) return 0;
        t = m_n / m_step();
        return (t > THETA_TOP) ? THETA_TOP : t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n         = 0;
        m_lat       = 0;
        m_armed     = 1'b0;
        m_frame     = 0;
        m_rev_prev  = 1'b0;
        m_revs      = 0;
        m_auto_prev = 1'b0;
        exp_q.delete();
        exp_q.push_back('{vld: 1'b0, addr: 0});
    endtask

    // One clock: predict the address for this cycle's inputs, advance the
    // model across the edge, then compare every main-instance output.
    task automatic tick();
        exp_t e;
        bit   edge_now;
        bit   stl;
        bit   toggled;
        edge_now = rev_in && !m_rev_prev;
        stl      = m_stalled();
        e.vld    = (m_lat != 0) && !stl;
        e.addr   = m_frame * FRAME_SIZE + clamp_px(int'(px_num)) * TEX_WIDTH
                 + ((m_theta() * TEX_WIDTH) >> THETA_BITS);
        exp_q.push_back(e);
        m_rev_prev = rev_in;
        toggled    = (auto_en != m_auto_prev);
        m_auto_prev = auto_en;
        @(posedge clk);
`ifdef POV_AUTO_ADVANCE_EN
        if (toggled) m_revs = 0;
`endif
        if (edge_now) begin
            if (!m_armed) m_lat = 0;
            else if (!stl) m_lat = m_n + 1;
            m_armed = 1'b1;
            m_n     = 0;
`ifdef POV_AUTO_ADVANCE_EN
            if (!auto_en) begin
                m_frame = clamp_frame(int'(frame_req));
            end else if (!toggled) begin
                m_revs++;
                if (m_revs > int'(auto_div)) begin
                    m_revs  = 0;
                    m_frame = (m_frame + 1) % NUM_FRAMES;
                end
            end
`else
            m_frame = clamp_frame(int'(frame_req));
`endif
        end else begin
            m_n++;
        end
        #1;
        e = exp_q.pop_front();
        check("theta", 32'(theta), 32'(m_theta()));
        check("stalled", 32'(stalled), 32'(m_stalled()));
        check("frame_cur", 32'(frame_cur), 32'(m_frame));
        check("addr_valid", 32'(addr_valid), 32'(e.vld));
        if (e.vld) check("rom_addr", 32'(rom_addr), e.addr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            px_num = 6'($urandom_range(0, 63));
            tick();
        end
    endtask

    task automatic pulse();
        rev_in = 1'b1;
        tick();
        rev_in = 1'b0;
    endtask

    task automatic pulse_s();
        rev_s = 1'b1;
        tick();
        rev_s = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"}, 32'(rom_addr), 0);
        check({tag, "_addr_valid"}, 32'(addr_valid), 0);
        check({tag, "_theta"}, 32'(theta), 0);
        check({tag, "_frame_cur"}, 32'(frame_cur), 0);
        check({tag, "_stalled"}, 32'(stalled), 0);
        check({tag, "_s_rom_addr"}, 32'(rom_addr_s), 0);
        check({tag, "_s_addr_valid"}, 32'(addr_valid_s), 0);
        check({tag, "_s_theta"}, 32'(theta_s), 0);
        check({tag, "_s_frame_cur"}, 32'(frame_cur_s), 0);
        check({tag, "_s_stalled"}, 32'(stalled_s), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        rev_in    = 1'b0;
        rev_s     = 1'b0;
        px_num    = '0;
        frame_req = '0;
        auto_en   = 1'b0;
        auto_div  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        model_reset();

        // First edge after reset carries no valid period.
        frame_req = 8'd2;
        run(20);
        pulse();
        check("frame_first_edge", 32'(frame_cur), 2);
        run(6399);
        pulse();                                  // period 6400 -> step 100
        run(99);
        check("theta_n99", 32'(theta), 0);
        run(1);
        check("theta_n100", 32'(theta), 1);
        run(900);                                 // theta = 10
        px_num = 6'd3;
        tick();
        tick();
        check("addr_f2_px3_t10", 32'(rom_addr), 27432);
        check("addr_valid_t10", 32'(addr_valid), 1);

        // Mid-revolution frame request must wait for the edge.
        frame_req = 8'd5;
        run(5397);
        check("frame_hold_mid_rev", 32'(frame_cur), 2);
        check("theta_last_step", 32'(theta), 63);
        pulse();
        check("frame_after_edge", 32'(frame_cur), 5);
        check("theta_zero_on_edge", 32'(theta), 0);

        // Longer revolution: theta saturates and holds, request clamps.
        frame_req = 8'd30;
        run(6300);
        check("theta_saturate", 32'(theta), 63);
        run(299);
        check("theta_hold", 32'(theta), 63);
        pulse();
        check("theta_after_long_rev", 32'(theta), 0);
        check("frame_clamped", 32'(frame_cur), 23);

        // Randomized revolutions and frame requests.
        for (int r = 0; r < 6; r++) begin
            int gap;
            gap       = int'($urandom_range(500, 900));
            frame_req = 8'($urandom_range(0, 40));
            auto_en   = 1'($urandom_range(0, 1));
            auto_div  = 8'($urandom_range(0, 2));
            run(gap / 2);
            frame_req = 8'($urandom_range(0, 40));
            run(gap - gap / 2 - 1);
            pulse();
        end

        auto_en   = 1'b0;
        run(10);
        frame_req = 8'd22;
        run(300);
        pulse();
        check("frame_22", 32'(frame_cur), 22);
`ifdef POV_AUTO_ADVANCE_EN
        auto_en  = 1'b1;
        auto_div = 8'd1;
        run(699);
        pulse();
        check("auto_edge1", 32'(frame_cur), 22);
        run(699);
        pulse();
        check("auto_edge2", 32'(frame_cur), 23);
        run(699);
        pulse();
        check("auto_edge3", 32'(frame_cur), 23);
        run(699);
        pulse();
        check("auto_wrap", 32'(frame_cur), 0);
        auto_en = 1'b0;
`else
        auto_en   = 1'b1;
        auto_div  = 8'd0;
        frame_req = 8'd7;
        run(699);
        pulse();
        check("auto_ignored", 32'(frame_cur), 7);
        auto_en = 1'b0;
`endif

        // Asynchronous reset in the middle of a revolution.
        run(300);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        #1 reset = 1'b0;
        model_reset();
        frame_req = 8'd4;
        run(200);
        pulse();
        check("rst_vld_edge_a", 32'(addr_valid), 0);
        run(599);
        pulse();
        check("rst_vld_edge_b0", 32'(addr_valid), 0);
        tick();
        check("rst_vld_edge_b1", 32'(addr_valid), 0);
        tick();
        check("rst_vld_edge_b2", 32'(addr_valid), 1);

        // Stall on the narrow-counter instance: period 640 -> step 10.
        pulse_s();
        run(639);
        pulse_s();
        run(639);
        pulse_s();
        run(50);
        check("s_theta_n50", 32'(theta_s), 5);
        check("s_valid_running", 32'(addr_valid_s), 1);
        run(971);
        check("s_not_stalled_n1021", 32'(stalled_s), 0);
        run(1);
        check("s_stalled_n1022", 32'(stalled_s), 1);
        check("s_theta_forced", 32'(theta_s), 0);
        run(78);
        check("s_stalled_n1100", 32'(stalled_s), 1);
        check("s_theta_n1100", 32'(theta_s), 0);
        check("s_valid_stalled", 32'(addr_valid_s), 0);
        pulse_s();
        check("s_stall_cleared", 32'(stalled_s), 0);
        run(50);
        check("s_period_kept", 32'(theta_s), 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
